// File: rtl/byte_dpram_mw.sv
// Byte-addressed dual-port RAM: port A reads and port B writes a run of 1..LANES consecutive entries per cycle.
// Read latency RD_LAT (1 or 2) cycles with a valid_a pulse; writes take effect at the request edge; error flags follow the pulses.
// No backpressure: one request per port per cycle at full rate, except while busy=1, when all requests are ignored.
//
// Ports: clk, rst_n (synchronous, active-low)
//        A: re_a, size_a, addr_a -> dout_a, valid_a, err_a
//        B: we_b, size_b, addr_b, din_b -> err_b
//        busy: post-reset clear in progress
// Optional feature: define DPRAM_CLEAR_EN to zero the memory after every reset.
// Without it, busy is tied 0 and contents survive reset.
module byte_dpram_mw #(
   parameter int ADDR_WIDTH  = 9,
   parameter int ADDR_LINE   = 432,
   parameter int DATA_WIDTH  = 8,
   parameter int INOUT_WIDTH = 128,
   parameter int RD_LAT      = 1
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         re_a,
   input  logic [$clog2(INOUT_WIDTH/DATA_WIDTH):0]      size_a,
   input  logic [ADDR_WIDTH-1:0]                        addr_a,
   output logic [INOUT_WIDTH-1:0]                       dout_a,
   output logic                                         valid_a,
   output logic                                         err_a,
   input  logic                                         we_b,
   input  logic [$clog2(INOUT_WIDTH/DATA_WIDTH):0]      size_b,
   input  logic [ADDR_WIDTH-1:0]                        addr_b,
   input  logic [INOUT_WIDTH-1:0]                       din_b,
   output logic                                         err_b,
   output logic                                         busy
);

   localparam int LANES = INOUT_WIDTH / DATA_WIDTH;
   localparam int SW    = $clog2(LANES) + 1;
   localparam logic [SW-1:0]         LANES_S = SW'(LANES);
   localparam logic [ADDR_WIDTH:0]   LINE_W  = (ADDR_WIDTH+1)'(ADDR_LINE);

   logic [DATA_WIDTH-1:0] mem [ADDR_LINE];

   // Entry index for lane 'lane' of a run starting at 'base'. base is in range
   // and lane < LANES, so a single subtraction is enough for the wrap.
   function automatic logic [ADDR_WIDTH-1:0] wrap_idx(input logic [ADDR_WIDTH-1:0] base,
                                                      input int lane);
      logic [ADDR_WIDTH:0] s;
      s = {1'b0, base} + (ADDR_WIDTH+1)'(lane);
      if (s >= LINE_W) s = s - LINE_W;
      return ADDR_WIDTH'(s);
   endfunction

   logic [SW-1:0]          eff_a;
   logic [SW-1:0]          eff_b;
   logic                   rd_acc;
   logic                   rd_err;
   logic                   wr_acc;
   logic                   wr_err;
   logic [INOUT_WIDTH-1:0] rd_data;

   assign eff_a = (size_a > LANES_S) ? LANES_S : size_a;
   assign eff_b = (size_b > LANES_S) ? LANES_S : size_b;

   // A zero-length run is a no-op even when the address is out of range.
   assign rd_acc = re_a && !busy && (eff_a != '0) && ({1'b0, addr_a} <  LINE_W);
   assign rd_err = re_a && !busy && (eff_a != '0) && ({1'b0, addr_a} >= LINE_W);
   assign wr_acc = we_b && !busy && (eff_b != '0) && ({1'b0, addr_b} <  LINE_W);
   assign wr_err = we_b && !busy && (eff_b != '0) && ({1'b0, addr_b} >= LINE_W);

   // Sampled combinationally from the array and registered at the request edge,
   // so a same-cycle overlapping write is not yet visible (read-first).
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i < int'(eff_a)) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[wrap_idx(addr_a, i)];
         end
      end
   end

`ifdef DPRAM_CLEAR_EN
   typedef enum logic {C_IDLE, C_CLEAR} clr_state_t;

   clr_state_t           clr_state;
   logic [ADDR_WIDTH:0]  clr_ptr;
   logic                 busy_r;

   // Reset parks the FSM in CLEAR at entry 0; each cycle after release
   // zeroes one group of LANES entries until the group that reaches the end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_state <= C_CLEAR;
         clr_ptr   <= '0;
         busy_r    <= 1'b1;
      end else begin
         case (clr_state)
            C_CLEAR: begin
               clr_ptr <= clr_ptr + (ADDR_WIDTH+1)'(LANES);
               if (clr_ptr + (ADDR_WIDTH+1)'(LANES) >= LINE_W) begin
                  clr_state <= C_IDLE;
                  busy_r    <= 1'b0;
               end
            end
            default: begin
               clr_state <= C_IDLE;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;
`else
   assign busy = 1'b0;
`endif

   // Memory array: no reset on the contents themselves.
   always_ff @(posedge clk) begin
      if (rst_n) begin
`ifdef DPRAM_CLEAR_EN
         if (clr_state == C_CLEAR) begin
            for (int i = 0; i < LANES; i++) begin
               // Last group is clipped at ADDR_LINE-1 rather than wrapped.
               if (clr_ptr + (ADDR_WIDTH+1)'(i) < LINE_W) begin
                  mem[ADDR_WIDTH'(clr_ptr + (ADDR_WIDTH+1)'(i))] <= '0;
               end
            end
         end
`endif
         if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
               if (i < int'(eff_b)) begin
                  mem[wrap_idx(addr_b, i)] <= din_b[i*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_b <= 1'b0;
      end else begin
         err_b <= wr_err;
      end
   end

   // Read return pipeline; dout_a only loads on a valid beat so it holds otherwise.
   if (RD_LAT == 2) begin : g_lat2
      logic                   p_vld;
      logic                   p_err;
      logic [INOUT_WIDTH-1:0] p_dat;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            p_vld   <= 1'b0;
            p_err   <= 1'b0;
            p_dat   <= '0;
            valid_a <= 1'b0;
            err_a   <= 1'b0;
            dout_a  <= '0;
         end else begin
            p_vld   <= rd_acc;
            p_err   <= rd_err;
            if (rd_acc) p_dat <= rd_data;
            valid_a <= p_vld;
            err_a   <= p_err;
            if (p_vld) dout_a <= p_dat;
         end
      end
   end else begin : g_lat1
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_a <= 1'b0;
            err_a   <= 1'b0;
            dout_a  <= '0;
         end else begin
            valid_a <= rd_acc;
            err_a   <= rd_err;
            if (rd_acc) dout_a <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_byte_dpram_mw.sv
// Directed bench for byte_dpram_mw at default parameters (RD_LAT=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Clear-feature steps are compiled only when DPRAM_CLEAR_EN is defined.
module tb_byte_dpram_mw;

   localparam int RD_LAT = 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         re_a;
   logic [4:0]   size_a;
   logic [8:0]   addr_a;
   logic [127:0] dout_a;
   logic         valid_a;
   logic         err_a;
   logic         we_b;
   logic [4:0]   size_b;
   logic [8:0]   addr_b;
   logic [127:0] din_b;
   logic         err_b;
   logic         busy;

   int total = 0;
   int bad   = 0;

   byte_dpram_mw #(
      .ADDR_WIDTH(9), .ADDR_LINE(432), .DATA_WIDTH(8), .INOUT_WIDTH(128), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .re_a(re_a), .size_a(size_a), .addr_a(addr_a), .dout_a(dout_a),
      .valid_a(valid_a), .err_a(err_a),
      .we_b(we_b), .size_b(size_b), .addr_b(addr_b), .din_b(din_b),
      .err_b(err_b), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [8:0] a, input logic [4:0] s, input logic [127:0] d);
      we_b = 1'b1; addr_b = a; size_b = s; din_b = d;
      step();
      we_b = 1'b0; size_b = '0;
   endtask

   // Issue one read and advance to the cycle its result is due.
   task automatic rd(input logic [8:0] a, input logic [4:0] s);
      re_a = 1'b1; addr_a = a; size_a = s;
      step();
      re_a = 1'b0; size_a = '0;
      repeat (RD_LAT - 1) step();
   endtask

`ifdef DPRAM_CLEAR_EN
   // Counts cycles until busy drops (bounded), noting any valid_a seen while re_a is held.
   task automatic wait_clear(output int cnt, output logic saw_vld);
      cnt = 0; saw_vld = 1'b0;
      while (busy && cnt < 60) begin
         step();
         cnt++;
         if (valid_a) saw_vld = 1'b1;
      end
   endtask
   int   ccnt;
   logic cvld;
`endif

   initial begin
      rst_n = 1'b0; re_a = 1'b0; we_b = 1'b0;
      size_a = '0; addr_a = '0; size_b = '0; addr_b = '0; din_b = '0;
      repeat (3) step();
      chk("rst_dout",  dout_a,  128'h0);
      chk("rst_valid", {127'h0, valid_a}, 128'h0);
      chk("rst_err_a", {127'h0, err_a},   128'h0);
      chk("rst_err_b", {127'h0, err_b},   128'h0);
`ifdef DPRAM_CLEAR_EN
      chk("rst_busy",  {127'h0, busy},    128'h1);
      // Release with a read held pending: it must be ignored throughout the clear.
      rst_n = 1'b1; re_a = 1'b1; addr_a = 9'd0; size_a = 5'd16;
      wait_clear(ccnt, cvld);
      re_a = 1'b0; size_a = '0;
      chk("clr_len",     128'(ccnt), 128'd27);
      chk("clr_no_vld",  {127'h0, cvld}, 128'h0);
      rd(9'd0, 5'd16);
      chk("clr_rd0",   dout_a, 128'h0);
      wr(9'd416, 5'd16, {16{8'hC3}});
      rd(9'd416, 5'd16);
      chk("pre_rd416", dout_a, {16{8'hC3}});
      // Reset again at clear cycle 10: the clear must restart and run a full 27 cycles.
      rst_n = 1'b0; step(); rst_n = 1'b1;
      repeat (10) step();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      wait_clear(ccnt, cvld);
      chk("clr_restart", 128'(ccnt), 128'd27);
      rd(9'd416, 5'd16);
      chk("clr_rd416", dout_a, 128'h0);
`else
      chk("rst_busy",  {127'h0, busy},    128'h0);
      rst_n = 1'b1;
`endif

      // Full-width write then read back.
      wr(9'd16, 5'd16, {16{8'hFF}});
      rd(9'd16, 5'd16);
      chk("rd16_vld",  {127'h0, valid_a}, 128'h1);
      chk("rd16_dat",  dout_a, {16{8'hFF}});
      step();
      chk("vld_pulse", {127'h0, valid_a}, 128'h0);
      chk("dout_hold", dout_a, {16{8'hFF}});

      // Partial write over a preloaded run.
      wr(9'd48, 5'd16, {16{8'h11}});
      wr(9'd48, 5'd8,  {16{8'hFF}});
      rd(9'd48, 5'd16);
      chk("partial_wr", dout_a, 128'h1111111111111111_FFFFFFFFFFFFFFFF);

      // Short read zeroes the upper lanes; size 0 is a silent no-op.
      rd(9'd48, 5'd4);
      chk("short_rd", dout_a, 128'h0000000000000000_00000000FFFFFFFF);
      rd(9'd48, 5'd0);
      chk("size0_vld", {127'h0, valid_a}, 128'h0);
      chk("size0_err", {127'h0, err_a},   128'h0);
      chk("size0_hold", dout_a, 128'h0000000000000000_00000000FFFFFFFF);

      // Size above LANES saturates to LANES.
      rd(9'd16, 5'd20);
      chk("size_sat", dout_a, {16{8'hFF}});

      // Wrap past the last entry; upper lanes of din_b must not be written.
      wr(9'd426, 5'd8, 128'hEEEEEEEEEEEEEEEE_0807060504030201);
      rd(9'd426, 5'd8);
      chk("wrap_rd", dout_a, 128'h0000000000000000_0807060504030201);
      rd(9'd430, 5'd4);
      chk("wrap_mid", dout_a, 128'h0000000000000000_0000000008070605);
      rd(9'd0, 5'd2);
      chk("wrap_low", dout_a, 128'h0000000000000000_0000000000000807);

      // Same-cycle overlapping read and write: read returns the old data.
      wr(9'd100, 5'd4, {16{8'h22}});
      re_a = 1'b1; addr_a = 9'd100; size_a = 5'd4;
      we_b = 1'b1; addr_b = 9'd100; size_b = 5'd4; din_b = {16{8'h33}};
      step();
      re_a = 1'b0; we_b = 1'b0; size_a = '0; size_b = '0;
      repeat (RD_LAT - 1) step();
      chk("coll_vld", {127'h0, valid_a}, 128'h1);
      chk("coll_old", dout_a, 128'h0000000000000000_0000000022222222);
      rd(9'd100, 5'd4);
      chk("coll_new", dout_a, 128'h0000000000000000_0000000033333333);

      // Out-of-range write: err_b one cycle later, nothing written anywhere near.
      wr(9'd2, 5'd14, {16{8'h5A}});
      we_b = 1'b1; addr_b = 9'd440; size_b = 5'd16; din_b = {16{8'hAB}};
      step();
      we_b = 1'b0; size_b = '0;
      chk("err_b_pulse", {127'h0, err_b}, 128'h1);
      step();
      chk("err_b_clear", {127'h0, err_b}, 128'h0);
      rd(9'd0, 5'd16);
      chk("oor_wr_nochg", dout_a, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A0807);

      // Out-of-range read: err_a after RD_LAT, no valid, dout holds.
      rd(9'd500, 5'd16);
      chk("err_a_pulse", {127'h0, err_a},   128'h1);
      chk("err_a_novld", {127'h0, valid_a}, 128'h0);
      chk("err_a_hold",  dout_a, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A0807);
      step();
      chk("err_a_clear", {127'h0, err_a}, 128'h0);

      // Back-to-back reads give back-to-back valid beats.
      re_a = 1'b1; addr_a = 9'd16; size_a = 5'd16;
      step();
      addr_a = 9'd48; size_a = 5'd8;
      repeat (RD_LAT - 1) step();
      chk("b2b_vld0", {127'h0, valid_a}, 128'h1);
      chk("b2b_dat0", dout_a, {16{8'hFF}});
      step();
      re_a = 1'b0; size_a = '0;
      chk("b2b_vld1", {127'h0, valid_a}, 128'h1);
      chk("b2b_dat1", dout_a, 128'h0000000000000000_FFFFFFFFFFFFFFFF);
      step();
      chk("b2b_end",  {127'h0, valid_a}, 128'h0);

      // Reset with a bad and a good request in flight: nothing follows reset.
      re_a = 1'b1; addr_a = 9'd500; size_a = 5'd16;
      step();
      rst_n = 1'b0; addr_a = 9'd16;
      step();
      re_a = 1'b0; size_a = '0;
      chk("rstmid_err",  {127'h0, err_a},   128'h0);
      chk("rstmid_vld",  {127'h0, valid_a}, 128'h0);
      chk("rstmid_dout", dout_a, 128'h0);
      rst_n = 1'b1;
      step();
      chk("rstmid_after", {126'h0, valid_a, err_a}, 128'h0);
`ifdef DPRAM_CLEAR_EN
      wait_clear(ccnt, cvld);
      rd(9'd16, 5'd16);
      chk("post_rst_clr", dout_a, 128'h0);
`else
      rd(9'd16, 5'd16);
      chk("post_rst_keep", dout_a, {16{8'hFF}});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
